// File: rtl/dds_pkg.sv
// Shared DDS datapath widths, used by the phase accumulator, sine LUT and mixer.
package dds_pkg;

    localparam int DDS_N_CH   = 4;   // independent DDS channels
    localparam int DDS_ACC_W  = 23;  // phase accumulator width
    localparam int DDS_OUT_W  = 14;  // truncated phase width fed to the LUT
    localparam int DDS_TUNE_W = 16;  // tuning word width

endpackage : dds_pkg

// File: rtl/multi_phase_accumulator.sv
// Time-multiplexed multi-channel DDS phase accumulator.
// One shared adder services channel sel each enabled cycle in strict
// round-robin order; the truncated, offset phase of that channel appears
// on phase_out one cycle later. Per-channel tune/offset words can be
// written at any time; phase clears requested via sync_req are held
// pending until the channel's next service slot.
module multi_phase_accumulator
    import dds_pkg::*;
#(
    parameter int N_CH   = DDS_N_CH,
    parameter int ACC_W  = DDS_ACC_W,
    parameter int OUT_W  = DDS_OUT_W,
    parameter int TUNE_W = DDS_TUNE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     wr_tune,
    input  logic                     wr_offset,
    input  logic [$clog2(N_CH)-1:0]  wr_ch,
    input  logic [TUNE_W-1:0]        wr_data,
    input  logic [N_CH-1:0]          sync_req,
    output logic [OUT_W-1:0]         phase_out,
    output logic [$clog2(N_CH)-1:0]  ph_ch,
    output logic                     ph_valid
);

    localparam int CH_W = $clog2(N_CH);

    // Per-channel state
    logic [ACC_W-1:0]  phase_r  [N_CH];
    logic [TUNE_W-1:0] tune_r   [N_CH];
    logic [OUT_W-1:0]  offset_r [N_CH];
    logic [N_CH-1:0]   pend_r;

    // Scheduler and output registers
    logic [CH_W-1:0]   sel_r;
    logic [OUT_W-1:0]  phase_out_r;
    logic [CH_W-1:0]   ph_ch_r;
    logic              ph_valid_r;

    // Datapath of the service cycle
    logic              clear_s;
    logic [ACC_W-1:0]  new_phase_s;
    logic [OUT_W-1:0]  out_phase_s;
    logic [CH_W-1:0]   sel_next_s;
    logic              wr_hit_s;

    // Shared adder: next phase of the serviced channel, its output word and the next slot
    always_comb begin
        clear_s     = pend_r[sel_r] | sync_req[sel_r];
        new_phase_s = '0;
        if (clear_s) begin
            new_phase_s = '0;
        end else begin
            new_phase_s = phase_r[sel_r] + ACC_W'(tune_r[sel_r]);
        end
        out_phase_s = new_phase_s[ACC_W-1 -: OUT_W] + offset_r[sel_r];
        sel_next_s  = '0;
        if (sel_r == CH_W'(N_CH - 1)) begin
            sel_next_s = '0;
        end else begin
            sel_next_s = sel_r + CH_W'(1);
        end
        wr_hit_s = (int'(wr_ch) < N_CH);
    end

    // Round-robin service: advance the serviced phase and register its output word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                phase_r[i] <= '0;
            end
            sel_r       <= '0;
            phase_out_r <= '0;
            ph_ch_r     <= '0;
            ph_valid_r  <= 1'b0;
        end else if (en) begin
            phase_r[sel_r] <= new_phase_s;
            sel_r          <= sel_next_s;
            phase_out_r    <= out_phase_s;
            ph_ch_r        <= sel_r;
            ph_valid_r     <= 1'b1;
        end else begin
            ph_valid_r     <= 1'b0;
        end
    end

    // Configuration writes; a serviced channel sees the new word from its next slot on
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                tune_r[i]   <= '0;
                offset_r[i] <= '0;
            end
        end else begin
            if (wr_tune && wr_hit_s) begin
                tune_r[wr_ch] <= wr_data;
            end
            if (wr_offset && wr_hit_s) begin
                offset_r[wr_ch] <= OUT_W'(ACC_W'(wr_data));
            end
        end
    end

    // Pending phase clears: consumed in the channel's slot, latched (merged) otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (en && (CH_W'(c) == sel_r)) begin
                    pend_r[c] <= 1'b0;
                end else if (sync_req[c]) begin
                    pend_r[c] <= 1'b1;
                end else begin
                    pend_r[c] <= pend_r[c];
                end
            end
        end
    end

    assign phase_out = phase_out_r;
    assign ph_ch     = ph_ch_r;
    assign ph_valid  = ph_valid_r;

endmodule : multi_phase_accumulator

// File: tb/tb_multi_phase_accumulator.sv
// Scoreboard bench for multi_phase_accumulator: a behavioural reference model
// predicts every output word, a monitor pops and compares on ph_valid.
module tb_multi_phase_accumulator;

    localparam int N_CH   = 4;
    localparam int ACC_W  = 23;
    localparam int OUT_W  = 14;
    localparam int TUNE_W = 16;
    localparam int CH_W   = $clog2(N_CH);
    localparam longint ACC_MOD = 64'd1 << ACC_W;
    localparam longint OUT_MOD = 64'd1 << OUT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              wr_tune = 1'b0;
    logic              wr_offset = 1'b0;
    logic [CH_W-1:0]   wr_ch = '0;
    logic [TUNE_W-1:0] wr_data = '0;
    logic [N_CH-1:0]   sync_req = '0;
    logic [OUT_W-1:0]  phase_out;
    logic [CH_W-1:0]   ph_ch;
    logic              ph_valid;

    multi_phase_accumulator #(
        .N_CH(N_CH), .ACC_W(ACC_W), .OUT_W(OUT_W), .TUNE_W(TUNE_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .wr_tune(wr_tune), .wr_offset(wr_offset),
        .wr_ch(wr_ch), .wr_data(wr_data), .sync_req(sync_req),
        .phase_out(phase_out), .ph_ch(ph_ch), .ph_valid(ph_valid)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int ph; } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Observation log written only by the monitor
    int hist [N_CH][$];
    int n_out = 0;
    int last_ch = -1;
    int last_ph = -1;

    // Reference model state
    longint m_phase [N_CH];
    longint m_tune  [N_CH];
    longint m_off   [N_CH];
    bit     m_pend  [N_CH];
    int     m_sel;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Monitor: compare every presented output against the head of the scoreboard
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ph_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got ch=%0d phase=0x%0h, expected no output", ph_ch, phase_out);
            end else begin
                e = exp_q.pop_front();
                if (int'(ph_ch) != e.ch || int'(phase_out) != e.ph) begin
                    errors++;
                    $display("FAIL output: got ch=%0d phase=0x%0h, expected ch=%0d phase=0x%0h",
                             ph_ch, phase_out, e.ch, e.ph);
                end
            end
            hist[ph_ch].push_back(int'(phase_out));
            n_out   = n_out + 1;
            last_ch = int'(ph_ch);
            last_ph = int'(phase_out);
        end
    end

    // Drive one clock cycle and advance the reference model by the same edge
    task automatic cycle(input bit r, input bit e, input bit wt, input bit wo,
                         input int ch, input int data, input bit [N_CH-1:0] sy);
        longint np;
        int s;
        @(negedge clk);
        rst = r; en = e; wr_tune = wt; wr_offset = wo;
        wr_ch = CH_W'(ch); wr_data = TUNE_W'(data); sync_req = sy;
        if (r) begin
            for (int c = 0; c < N_CH; c++) begin
                m_phase[c] = 0; m_tune[c] = 0; m_off[c] = 0; m_pend[c] = 0;
            end
            m_sel = 0;
        end else begin
            s = m_sel;
            if (e) begin
                if (m_pend[s] || sy[s]) np = 0;
                else np = (m_phase[s] + m_tune[s]) % ACC_MOD;
                exp_q.push_back('{ch: s, ph: int'(((np >> (ACC_W - OUT_W)) + m_off[s]) % OUT_MOD)});
                m_phase[s] = np;
                m_sel = (s + 1) % N_CH;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (e && c == s) m_pend[c] = 0;
                else if (sy[c]) m_pend[c] = 1;
            end
            if (ch < N_CH) begin
                if (wt) m_tune[ch] = longint'(data) % (64'd1 << TUNE_W);
                if (wo) m_off[ch]  = longint'(data) % OUT_MOD;
            end
        end
        @(posedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, '0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1, 16'h1234, '1);
        idle();
    endtask

    task automatic wr(input bit wt, input bit wo, input int ch, input int data);
        cycle(1'b0, 1'b0, wt, wo, ch, data, '0);
    endtask

    int base [N_CH];
    int nb;

    task automatic mark();
        for (int c = 0; c < N_CH; c++) base[c] = hist[c].size();
    endtask

    initial begin
        // Reset state
        do_reset();
        #2;
        chk("reset_valid", ph_valid, 0);
        chk("reset_phase", phase_out, 0);
        chk("reset_ch", ph_ch, 0);

        // Single tuned channel: ch0 counts 1,2,3..., others stay 0
        wr(1'b1, 1'b0, 0, 16'h0200);
        mark();
        run(20);
        idle();
        #2;
        chk("idle_valid_low", ph_valid, 0);
        chk("ch0_first", hist[0][base[0]], 1);
        chk("ch0_fifth", hist[0][base[0] + 4], 5);
        chk("ch1_stays_zero", hist[1][hist[1].size() - 1], 0);
        chk("ch3_stays_zero", hist[3][hist[3].size() - 1], 0);

        // Accumulator wrap mod 2^23
        do_reset();
        wr(1'b1, 1'b0, 2, 16'hFFFF);
        mark();
        run(129 * N_CH);
        idle();
        chk("ch2_service_count", hist[2].size() - base[2], 129);
        chk("ch2_wrap_129th", hist[2][base[2] + 128], 127);

        // Offset wrap mod 2^14
        do_reset();
        wr(1'b1, 1'b0, 1, 16'h0200);
        wr(1'b0, 1'b1, 1, 16'h3FFF);
        mark();
        run(12);
        idle();
        chk("ch1_off_wrap0", hist[1][base[1]], 0);
        chk("ch1_off_wrap1", hist[1][base[1] + 1], 1);
        chk("ch1_off_wrap2", hist[1][base[1] + 2], 2);

        // Sync request for ch3 during ch1's slot
        do_reset();
        wr(1'b1, 1'b0, 3, 16'h0200);
        wr(1'b0, 1'b1, 3, 16'h0123);
        mark();
        run(8);
        run(1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 4'b1000);
        run(6);
        idle();
        chk("sync_pre", hist[3][base[3] + 1], 16'h0125);
        chk("sync_clear", hist[3][base[3] + 2], 16'h0123);
        chk("sync_resume", hist[3][base[3] + 3], 16'h0124);

        // Tune write in the channel's own service cycle
        do_reset();
        wr(1'b1, 1'b0, 0, 16'h0200);
        mark();
        run(4);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 16'h0400, '0);
        run(4);
        idle();
        chk("selfwr_old_tune", hist[0][base[0] + 1], 2);
        chk("selfwr_new_tune", hist[0][base[0] + 2], 4);

        // Reset mid-sweep
        do_reset();
        wr(1'b1, 1'b1, 0, 16'h7A31);
        wr(1'b1, 1'b0, 2, 16'h1C05);
        run(6);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1, 16'h5555, 4'b0110);
        #2;
        chk("midrst_valid", ph_valid, 0);
        chk("midrst_phase", phase_out, 0);
        nb = n_out;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, '0);
        idle();
        chk("postrst_count", n_out - nb, 1);
        chk("postrst_ch", last_ch, 0);
        chk("postrst_phase", last_ph, 0);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit [N_CH-1:0] sy;
            for (int c = 0; c < N_CH; c++) sy[c] = ($urandom_range(0, 15) == 0);
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, N_CH - 1), int'($urandom_range(0, 65535)), sy);
        end
        idle();
        idle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multi_phase_accumulator

// File: doc/multi_phase_accumulator.md
MULTI_PHASE_ACCUMULATOR -- requirements
Module: multi_phase_accumulator

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent DDS channels (2..16).
REQ-002 SHALL have parameter ACC_W, default 23: phase accumulator width per channel.
REQ-003 SHALL have parameter OUT_W, default 14: truncated phase output width (OUT_W <= ACC_W).
REQ-004 SHALL have parameter TUNE_W, default 16: tuning word width (TUNE_W <= ACC_W).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit: advance enable for the channel scheduler.
REQ-008 SHALL have port wr_tune, input, 1 bit: write strobe for a tuning word.
REQ-009 SHALL have port wr_offset, input, 1 bit: write strobe for a phase offset.
REQ-010 SHALL have port wr_ch, input, clog2(N_CH) bits: target channel of the write.
REQ-011 SHALL have port wr_data, input, TUNE_W bits: write data; the offset uses the low OUT_W bits.
REQ-012 SHALL have port sync_req, input, N_CH bits: per-channel phase-clear request.
REQ-013 SHALL have port phase_out, output, OUT_W bits: truncated and offset phase of ph_ch.
REQ-014 SHALL have port ph_ch, output, clog2(N_CH) bits: channel index of phase_out.
REQ-015 SHALL have port ph_valid, output, 1 bit: phase_out and ph_ch are valid this cycle.

Function
REQ-016 SHALL time-multiplex one adder, servicing channel sel = 0,1,...,N_CH-1,0,... with one channel per cycle while en=1.
REQ-017 SHALL hold sel, all phases and pending clears, and drive ph_valid=0, in every cycle with en=0.
REQ-018 SHALL, in a service cycle, update the channel phase as phase[sel] <= (phase[sel] + zero-extended tune[sel]) mod 2^ACC_W.
REQ-019 SHALL instead load phase[sel] <= 0 when a clear is pending for sel or sync_req[sel]=1 in that service cycle, then drop the pending flag.
REQ-020 SHALL latch a sync_req[c] bit arriving outside channel c's service slot as pending, with repeated requests merging into one.
REQ-021 SHALL register phase_out = (new_phase[ACC_W-1 -: OUT_W] + offset[sel]) mod 2^OUT_W, with ph_ch=sel and ph_valid=1, one cycle after the service cycle (latency 1).
REQ-022 SHALL, when en=1, emit exactly one valid output per cycle, with ph_ch strictly round-robin.
REQ-023 SHALL write tune[wr_ch] or offset[wr_ch] at the clock edge of the strobe, whether en is 0 or 1.
REQ-024 SHALL, when a write targets the channel being serviced, use the old value in that service and the new value from the next service onward.
REQ-025 SHALL, when wr_tune and wr_offset are both 1, perform both writes with the same wr_data.
REQ-026 SHALL ignore writes with wr_ch >= N_CH.

Reset
REQ-027 SHALL, while rst=1, set all phases, tunes, offsets and pending flags to 0, and set sel=0, phase_out=0, ph_ch=0, ph_valid=0; rst overrides en, writes and sync_req.
REQ-028 SHALL, after rst falls with en=1, service channel 0 first, with its ph_valid high one cycle later.
REQ-029 SHALL abandon a service cycle in progress when reset is asserted mid-sweep, with no partial update surviving.

Structure
REQ-030 SHALL take its default widths (ACC_W, OUT_W, TUNE_W, N_CH) from the shared package dds_pkg, for reuse by the sine LUT and mixer.
REQ-031 SHALL keep per-channel state in register arrays with a single adder, and SHALL have no sub-module.

Verification
REQ-032 SHALL verify, with defaults, en=1, tune[0]=0x0200 and other tunes 0, that successive ch0 outputs are 1,2,3,... and ch1..3 outputs stay 0.
REQ-033 SHALL verify that tune[2]=0xFFFF gives ch2 phase_out=127 at its 129th service, proving accumulator wrap mod 2^23.
REQ-034 SHALL verify that offset[1]=0x3FFF with tune[1]=0x0200 gives ch1 outputs 0x0000,0x0001,... (offset wrap mod 2^14).
REQ-035 SHALL verify that sync_req[3] pulsed while ch1 is serviced makes ch3's next output equal offset[3], with accumulation resuming afterward.
REQ-036 SHALL verify that wr_tune to ch0 in ch0's own service cycle leaves that output on the old tune, with the new tune applying next sweep.
REQ-037 SHALL verify that rst asserted mid-sweep clears phase_out/ph_valid next cycle, and that the first post-reset output has ph_ch=0 and phase_out=0.
